// File: rtl/lcd_nibble_reader_pkg.sv
// Shared definitions for the LCD 4-bit read path: reader state encodings,
// default read-cycle timing (in 50 MHz clock cycles), the busy-flag bit
// position, and the HD44780 register-select encodings shared with the writer.
package lcd_nibble_reader_pkg;

  // Reader FSM state encodings
  localparam logic [2:0] RD_ST_IDLE     = 3'd0;
  localparam logic [2:0] RD_ST_SETUP    = 3'd1;
  localparam logic [2:0] RD_ST_E_HI1    = 3'd2;
  localparam logic [2:0] RD_ST_GAP      = 3'd3;
  localparam logic [2:0] RD_ST_E_HI2    = 3'd4;
  localparam logic [2:0] RD_ST_HOLD     = 3'd5;
  localparam logic [2:0] RD_ST_POLL_GAP = 3'd6;
  localparam logic [2:0] RD_ST_DONE     = 3'd7;

  // Default timing, in clock cycles
  localparam int RD_T_SETUP       = 2;
  localparam int RD_T_E_HIGH      = 12;
  localparam int RD_T_E_LOW       = 50;
  localparam int RD_T_HOLD        = 1;
  localparam int RD_POLL_TIMEOUT  = 100000;

  // Busy flag position in the status byte
  localparam int BF_BIT = 7;

  // LCD_RS encodings
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_delay_counter.sv
// Load/terminal-count down-counter used to time each phase of a read cycle.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : value loaded; a phase of N cycles loads N-1
//   tc_o         : terminal count, high while the count is zero
module lcd_delay_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_reader.sv
// HD44780 4-bit read engine. Runs one status/data read (two E strobes, high
// nibble then low nibble) or repeats status reads until the busy flag clears,
// and returns the assembled byte with a one-cycle rsp_valid pulse.
//   clk, rst                : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE/DONE)
//   req_rs, req_poll        : register select; busy-flag poll mode
//   rsp_valid/rsp_data      : response pulse and byte (held between responses)
//   rsp_timeout             : poll gave up with BF still set
//   bus_own                 : reader owns the LCD control lines
//   LCD_E, LCD_RS, LCD_RW   : LCD control outputs (all registered)
//   DB_I                    : LCD DB[7:4] sampled from the pad
module lcd_nibble_reader
  import lcd_nibble_reader_pkg::*;
#(
  parameter int T_SETUP      = RD_T_SETUP,
  parameter int T_E_HIGH     = RD_T_E_HIGH,
  parameter int T_E_LOW      = RD_T_E_LOW,
  parameter int T_HOLD       = RD_T_HOLD,
  parameter int POLL_TIMEOUT = RD_POLL_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       bus_own,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  input  logic [3:0] DB_I
);

  localparam int CNT_W = 16;
  // A phase lasting N cycles loads N-1 so it ends on the edge where tc is seen.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_E_HI  = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_E_LO  = CNT_W'(T_E_LOW - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [31:0]      TMO_LIM  = 32'(POLL_TIMEOUT);
  // BF lives in the high nibble
  localparam int               BF_NIB   = BF_BIT - 4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [2:0]       state_q, state_d;
  logic             e_q, e_d, rs_q, rs_d, rw_q, rw_d, own_q, own_d;
  logic             ready_q, ready_d, valid_q, valid_d, tmo_q, tmo_d;
  logic             poll_q, poll_d;
  logic [7:0]       data_q, data_d;
  logic [31:0]      elapsed_q, elapsed_d;
  logic [3:0]       hi_q, hi_d, lo_q, lo_d;
  logic             cnt_load, cnt_tc;
  logic [CNT_W-1:0] cnt_val;
  logic             accept;

  assign accept = req_valid && ready_q;

  lcd_delay_counter #(.CNT_W(CNT_W)) u_dly (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    rs_d      = rs_q;
    rw_d      = rw_q;
    own_d     = own_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    tmo_d     = tmo_q;
    poll_d    = poll_q;
    data_d    = data_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    elapsed_d = (state_q == RD_ST_IDLE) ? elapsed_q : sat_inc32(elapsed_q);
    case (state_q)
      RD_ST_IDLE, RD_ST_DONE: begin
        state_d = RD_ST_IDLE;
        // DONE keeps ready high, so a waiting request is taken straight away
        if (accept) begin
          rs_d      = (req_poll || !req_rs) ? RS_CMD : RS_DATA;
          rw_d      = 1'b1;
          own_d     = 1'b1;
          ready_d   = 1'b0;
          poll_d    = req_poll;
          tmo_d     = 1'b0;
          elapsed_d = '0;
          state_d   = RD_ST_SETUP;
          cnt_load  = 1'b1;
          cnt_val   = LD_SETUP;
        end
      end
      RD_ST_SETUP: if (cnt_tc) begin
        state_d  = RD_ST_E_HI1;
        e_d      = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = LD_E_HI;
      end
      RD_ST_E_HI1: if (cnt_tc) begin
        state_d  = RD_ST_GAP;
        e_d      = 1'b0;
        hi_d     = DB_I;
        cnt_load = 1'b1;
        cnt_val  = LD_E_LO;
      end
      RD_ST_GAP: if (cnt_tc) begin
        state_d  = RD_ST_E_HI2;
        e_d      = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = LD_E_HI;
      end
      RD_ST_E_HI2: if (cnt_tc) begin
        e_d      = 1'b0;
        lo_d     = DB_I;
        cnt_load = 1'b1;
        state_d  = RD_ST_HOLD;
        cnt_val  = LD_HOLD;
        if (poll_q && hi_q[BF_NIB]) begin
          if (elapsed_q >= TMO_LIM) begin
            tmo_d = 1'b1;
          end else begin
            state_d = RD_ST_POLL_GAP;
            cnt_val = LD_E_LO;
          end
        end
      end
      RD_ST_POLL_GAP: if (cnt_tc) begin
        state_d  = RD_ST_SETUP;
        cnt_load = 1'b1;
        cnt_val  = LD_SETUP;
      end
      RD_ST_HOLD: if (cnt_tc) begin
        state_d = RD_ST_DONE;
        rw_d    = 1'b0;
        own_d   = 1'b0;
        ready_d = 1'b1;
        valid_d = 1'b1;
        data_d  = {hi_q, lo_q};
      end
      default: state_d = RD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RD_ST_IDLE;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      own_q     <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
      poll_q    <= 1'b0;
      data_q    <= '0;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      rs_q      <= rs_d;
      rw_q      <= rw_d;
      own_q     <= own_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
      poll_q    <= poll_d;
      data_q    <= data_d;
      elapsed_q <= elapsed_d;
    end
  end

  // Nibble capture registers; a partial byte is never exposed, so no reset
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = valid_q;
  assign rsp_data    = data_q;
  assign rsp_timeout = tmo_q;
  assign bus_own     = own_q;
  assign LCD_E       = e_q;
  assign LCD_RS      = rs_q;
  assign LCD_RW      = rw_q;

endmodule

// File: tb/tb_lcd_nibble_reader.sv
module tb_lcd_nibble_reader;

  localparam int TMO  = 500;
  localparam int T_SU = 2;
  localparam int T_EH = 12;
  localparam int T_EL = 50;
  localparam int T_HD = 1;
  // single read latency and the extra cost of each further poll read
  localparam int LAT  = T_SU + 2 * T_EH + T_EL + T_HD;
  localparam int PER  = T_EL + T_SU + 2 * T_EH + T_EL;

  typedef struct {
    logic [7:0] data;
    logic       tmo;
    logic       rs;
    int         lat;
    int         reads;
    int         k;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b0;
  logic       req_valid = 1'b0, req_rs = 1'b0, req_poll = 1'b0;
  logic [3:0] DB_I = 4'h0;
  logic       req_ready, rsp_valid, rsp_timeout, bus_own, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] rsp_data;

  int checks = 0, failures = 0, cyc = 0;
  exp_t       expq[$];
  logic [3:0] nibq[$];

  int   rises, last_rise, last_fall, last_ctl;
  logic prev_e, prev_rs, prev_rw;
  bit   own_bad;

  lcd_nibble_reader #(.POLL_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_rs     (req_rs),
    .req_poll   (req_poll),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .bus_own    (bus_own),
    .LCD_E      (LCD_E),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .DB_I       (DB_I)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // LCD model: presents the next queued nibble while E is high, noise otherwise
  initial begin
    forever begin
      @(posedge LCD_E);
      #1 DB_I = (nibq.size() > 0) ? nibq.pop_front() : 4'h0;
      @(negedge LCD_E);
      #1 DB_I = 4'($urandom);
    end
  end

  // Monitor: bus timing checks and scoreboard pops on rsp_valid
  initial begin
    exp_t e;
    rises = 0; last_rise = 0; last_fall = 0; last_ctl = 0; own_bad = 0;
    prev_e = 1'b0; prev_rs = 1'b0; prev_rw = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rises = 0; own_bad = 0; last_ctl = cyc;
      end else begin
        if (LCD_RS !== prev_rs || LCD_RW !== prev_rw) begin
          check(!LCD_E, "ctl_change_while_e", int'(LCD_E), 0);
          last_ctl = cyc;
        end
        if (LCD_E && !prev_e) begin
          check(cyc - last_ctl >= T_SU, "setup_before_e", cyc - last_ctl, T_SU);
          check(LCD_RS === ((expq.size() > 0) ? expq[0].rs : 1'b0), "rs_value",
                int'(LCD_RS), (expq.size() > 0) ? int'(expq[0].rs) : 0);
          if (rises > 0)
            check(cyc - last_fall == ((rises % 2 == 1) ? T_EL : T_EL + T_SU), "e_low_len",
                  cyc - last_fall, (rises % 2 == 1) ? T_EL : T_EL + T_SU);
          rises++;
          last_rise = cyc;
        end
        if (!LCD_E && prev_e) begin
          check(cyc - last_rise == T_EH, "e_high_len", cyc - last_rise, T_EH);
          last_fall = cyc;
        end
        if (rsp_valid) begin
          check(expq.size() > 0, "spurious_rsp", expq.size(), 1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            check(rsp_data == e.data, "rsp_data", int'(rsp_data), int'(e.data));
            check(rsp_timeout == e.tmo, "rsp_timeout", int'(rsp_timeout), int'(e.tmo));
            check(cyc == e.k + e.lat, "latency", cyc - e.k, e.lat);
            check(rises == 2 * e.reads, "e_pulses", rises, 2 * e.reads);
            check(!LCD_RW && !bus_own, "bus_release", int'({LCD_RW, bus_own}), 0);
            check(req_ready, "ready_at_rsp", int'(req_ready), 1);
            check(!own_bad, "own_held", int'(own_bad), 0);
            check(cyc - last_fall == T_HD, "rw_hold", cyc - last_fall, T_HD);
          end
          rises = 0; own_bad = 0;
        end else if (expq.size() > 0 && cyc > expq[0].k) begin
          if (!(bus_own && LCD_RW)) own_bad = 1;
        end
      end
      prev_e = LCD_E; prev_rs = LCD_RS; prev_rw = LCD_RW;
    end
  end

  // Builds the bytes the LCD will return, predicts the response from the
  // read rules, then offers the request until accepted.
  task automatic issue(input logic rs, input logic poll, input int nbusy,
                       input logic [7:0] last, output int k);
    logic [7:0] rd [16];
    exp_t e;
    int   i, guard;
    for (int j = 0; j < 16; j++)
      rd[j] = (j < nbusy) ? (8'h80 | 8'($urandom)) : (poll ? (last & 8'h7F) : last);
    i = 0;
    // the elapsed count seen at read i's decision is (LAT-1)+PER*i minus one
    if (poll)
      while (i < 15 && rd[i][7] && (LAT - 2 + PER * i) < TMO) i++;
    e.data  = rd[i];
    e.tmo   = poll && rd[i][7];
    e.reads = i + 1;
    e.lat   = LAT + PER * i;
    e.rs    = poll ? 1'b0 : rs;
    @(negedge clk);
    req_rs = rs; req_poll = poll; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check(req_ready, "accept_wait", guard, 0);
    if (!req_ready) begin
      k = -1;
      return;
    end
    e.k = cyc + 1;
    k = e.k;
    for (int j = 0; j < e.reads; j++) begin
      nibq.push_back(rd[j][7:4]);
      nibq.push_back(rd[j][3:0]);
    end
    expq.push_back(e);
    @(posedge clk);
  endtask

  task automatic drain();
    int guard;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (expq.size() > 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check(expq.size() == 0, "drain_timeout", expq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k1, k2, guard, nb;
    logic p;
    #1 rst = 1'b1;
    #1;
    check(req_ready == 1'b1, "rst_req_ready", int'(req_ready), 1);
    check(rsp_valid == 1'b0, "rst_rsp_valid", int'(rsp_valid), 0);
    check(rsp_data == 8'h00, "rst_rsp_data", int'(rsp_data), 0);
    check(rsp_timeout == 1'b0, "rst_rsp_timeout", int'(rsp_timeout), 0);
    check(bus_own == 1'b0, "rst_bus_own", int'(bus_own), 0);
    check(LCD_E == 1'b0, "rst_lcd_e", int'(LCD_E), 0);
    check(LCD_RS == 1'b0, "rst_lcd_rs", int'(LCD_RS), 0);
    check(LCD_RW == 1'b0, "rst_lcd_rw", int'(LCD_RW), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // data read returning 0x48
    issue(1'b1, 1'b0, 0, 8'h48, k1);
    drain();
    // poll: BF=1 for three reads, then status 0x05
    issue(1'b1, 1'b1, 3, 8'h05, k1);
    drain();
    // poll with BF stuck at 1 until timeout
    issue(1'b0, 1'b1, 16, 8'hFF, k1);
    drain();

    // req_valid held high across a whole read
    issue(1'b1, 1'b0, 0, 8'h3C, k1);
    issue(1'b0, 1'b0, 0, 8'hC3, k2);
    check(k2 == k1 + LAT + 1, "back_to_back_accept", k2 - k1, LAT + 1);
    drain();

    for (int n = 0; n < 8; n++) begin
      p  = 1'($urandom_range(0, 1));
      nb = p ? (($urandom_range(0, 4) == 0) ? 6 : int'($urandom_range(0, 3))) : 0;
      issue(1'($urandom_range(0, 1)), p, nb, 8'($urandom), k1);
      drain();
    end

    // reset during the second E pulse
    issue(1'b1, 1'b0, 0, 8'hA5, k1);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (rises < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(rises == 2, "reach_e_hi2", rises, 2);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check(LCD_E == 1'b0, "midrst_lcd_e", int'(LCD_E), 0);
    check(LCD_RW == 1'b0, "midrst_lcd_rw", int'(LCD_RW), 0);
    check(bus_own == 1'b0, "midrst_bus_own", int'(bus_own), 0);
    check(req_ready == 1'b1, "midrst_req_ready", int'(req_ready), 1);
    expq.delete();
    nibq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    issue(1'b1, 1'b0, 0, 8'h5A, k1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
